// File: rtl/alu_seq_pkg.sv
// Shared types for the alu_4bit command path: FSM states, opcode encoding and the queued command.
// The command layout depends on ALU_CHAIN_EN (adds a chain flag per entry).
package alu_seq_pkg;

  localparam int DATA_W = 4;
  localparam int OP_W   = 3;
  localparam int RES_W  = 8;

  // alu_4bit opcode encoding
  localparam logic [OP_W-1:0] OP_ADD = 3'd0;
  localparam logic [OP_W-1:0] OP_SUB = 3'd1;
  localparam logic [OP_W-1:0] OP_AND = 3'd2;
  localparam logic [OP_W-1:0] OP_OR  = 3'd3;
  localparam logic [OP_W-1:0] OP_XOR = 3'd4;
  localparam logic [OP_W-1:0] OP_NOT = 3'd5;
  localparam logic [OP_W-1:0] OP_SHL = 3'd6;
  localparam logic [OP_W-1:0] OP_SHR = 3'd7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef struct packed {
`ifdef ALU_CHAIN_EN
    logic              chain;
`endif
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] a;
  } cmd_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous FIFO of DEPTH entries (power of two). Push is refused when full and pop when empty,
// even if the other side moves in the same cycle; read data is the head entry, combinational.
module alu_cmd_fifo #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Pointers wrap for free because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Queues {op, B, A} commands and issues them one at a time to alu_4bit, capturing each result.
// Optional macro ALU_CHAIN_EN: a queued command may take A from the previous captured result.
module alu_cmd_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int ALU_LAT = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W-1:0]       in_a,
  input  logic [DATA_W-1:0]       in_b,
  input  logic [OP_W-1:0]         in_op,
  input  logic                    in_chain,
  input  logic                    issue_en,
  output logic [DATA_W-1:0]       alu_a,
  output logic [DATA_W-1:0]       alu_b,
  output logic [OP_W-1:0]         alu_op,
  output logic                    alu_issue,
  input  logic [RES_W-1:0]        alu_res,
  output logic                    res_valid,
  output logic [RES_W-1:0]        res_out,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    busy,
  output state_e                  dbg_state_o
);

  // Handshake: a command transfers on a rising edge where in_valid && in_ready;
  // in_ready depends only on registered occupancy, never on the same-cycle pop.

  localparam int WCNT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  localparam logic [WCNT_W-1:0] WCNT_INIT = WCNT_W'(ALU_LAT - 1);

  state_e            state_q, state_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [RES_W-1:0]  res_q, res_d;
  logic              pop;
  logic              fifo_full, fifo_empty;
  cmd_t              wr_cmd, hd_cmd;

  always_comb begin
    wr_cmd    = '0;
    wr_cmd.a  = in_a;
    wr_cmd.b  = in_b;
    wr_cmd.op = in_op;
`ifdef ALU_CHAIN_EN
    wr_cmd.chain = in_chain;
`endif
  end

`ifndef ALU_CHAIN_EN
  logic unused_chain;
  assign unused_chain = in_chain;
`endif

  alu_cmd_fifo #(
    .WIDTH ($bits(cmd_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (in_valid),
    .pop_i   (pop),
    .wdata_i (wr_cmd),
    .rdata_o (hd_cmd),
    .count_o (count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      res_q   <= res_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    res_d   = res_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty && issue_en) begin
          pop     = 1'b1;
          a_d     = hd_cmd.a;
`ifdef ALU_CHAIN_EN
          if (hd_cmd.chain) a_d = res_q[DATA_W-1:0];
`endif
          b_d     = hd_cmd.b;
          op_d    = hd_cmd.op;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        wcnt_d  = WCNT_INIT;
        state_d = WAIT;
      end
      WAIT: begin
        if (wcnt_q == '0) begin
          res_d   = alu_res;
          state_d = DONE;
        end else begin
          wcnt_d = wcnt_q - 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand lines are registers that only change on a pop, so the ALU sees stable inputs.
  assign alu_a       = a_q;
  assign alu_b       = b_q;
  assign alu_op      = op_q;
  assign alu_issue   = (state_q == ISSUE);
  assign res_valid   = (state_q == DONE);
  assign res_out     = res_q;
  assign busy        = (state_q != IDLE);
  assign in_ready    = !fifo_full;
  assign dbg_state_o = state_q;

endmodule
